// File: rtl/if_fetch.sv
// Instruction-fetch stage: single-outstanding bus read from the current PC, registered for decode.
// Optional IF_FETCH_PERF_EN adds delivered-instruction and stall-cycle counters.
module if_fetch #(
  parameter int unsigned      ADDR_W   = 32,
  parameter int unsigned      DATA_W   = 32,
  parameter logic [2:0]       HOLD_IF  = 3'b010,
  parameter logic [DATA_W-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              jump_flag_i,
  input  logic [2:0]        hold_flag_i,
  input  logic              jtag_reset_flag_i,
  output logic              ibus_req_o,
  output logic [ADDR_W-1:0] ibus_addr_o,
  input  logic              ibus_gnt_i,
  input  logic              ibus_rvalid_i,
  input  logic [DATA_W-1:0] ibus_rdata_i,
  output logic [DATA_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_valid_o,
  output logic              stall_req_o
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]       perf_inst_o,
  output logic [31:0]       perf_stall_o
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              drop_q, drop_d;
  logic              pend_valid_q, pend_valid_d;
  logic [DATA_W-1:0] pend_data_q, pend_data_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;
  logic              inst_valid_q, inst_valid_d;

  logic flush;
  logic held;
  logic deliver;
  logic load_real;

  assign flush   = jump_flag_i | jtag_reset_flag_i;
  assign held    = (hold_flag_i >= HOLD_IF);
  // A response is only usable if nothing flushed it before or during its arrival.
  assign deliver = (state_q == WAIT) && ibus_rvalid_i && !drop_q && !flush;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drop_d  = drop_q;
    unique case (state_q)
      IDLE: begin
        if (!flush && !held && !pend_valid_q) begin
          addr_d  = pc_i;
          state_d = REQ;
        end
      end
      REQ: begin
        if (flush) drop_d = 1'b1;
        if (ibus_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (ibus_rvalid_i) begin
          state_d = IDLE;
          drop_d  = 1'b0;
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        drop_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    inst_d       = inst_q;
    inst_addr_d  = inst_addr_q;
    inst_valid_d = inst_valid_q;
    pend_valid_d = pend_valid_q;
    pend_data_d  = pend_data_q;
    pend_addr_d  = pend_addr_q;
    load_real    = 1'b0;
    if (flush) begin
      inst_d       = NOP_INST;
      inst_valid_d = 1'b0;
      pend_valid_d = 1'b0;
    end else if (deliver && held) begin
      pend_data_d  = ibus_rdata_i;
      pend_addr_d  = addr_q;
      pend_valid_d = 1'b1;
    end else if (deliver) begin
      inst_d       = ibus_rdata_i;
      inst_addr_d  = addr_q;
      inst_valid_d = 1'b1;
      load_real    = 1'b1;
    end else if (pend_valid_q && !held) begin
      inst_d       = pend_data_q;
      inst_addr_d  = pend_addr_q;
      inst_valid_d = 1'b1;
      pend_valid_d = 1'b0;
      load_real    = 1'b1;
    end else if (!held) begin
      inst_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      drop_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_data_q  <= '0;
      pend_addr_q  <= '0;
      inst_q       <= NOP_INST;
      inst_addr_q  <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      drop_q       <= drop_d;
      pend_valid_q <= pend_valid_d;
      pend_data_q  <= pend_data_d;
      pend_addr_q  <= pend_addr_d;
      inst_q       <= inst_d;
      inst_addr_q  <= inst_addr_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign ibus_req_o   = (state_q == REQ);
  assign ibus_addr_o  = addr_q;
  assign inst_o       = inst_q;
  assign inst_addr_o  = inst_addr_q;
  assign inst_valid_o = inst_valid_q;
  // The PC may advance only once the current word is certain to be captured.
  assign stall_req_o  = !(deliver || pend_valid_q);

`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_inst_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_inst_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (load_real && (perf_inst_q != 32'hFFFF_FFFF)) perf_inst_q <= perf_inst_q + 32'd1;
      if (stall_req_o && (perf_stall_q != 32'hFFFF_FFFF)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_inst_o  = perf_inst_q;
  assign perf_stall_o = perf_stall_q;
`else
  logic unused_load_real;
  assign unused_load_real = load_real;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios followed by random traffic against a transaction-level model.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [31:0] pc_i;
  logic        jump_flag_i;
  logic [2:0]  hold_flag_i;
  logic        jtag_reset_flag_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic        stall_req_o;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_inst_o;
  logic [31:0] perf_stall_o;
`endif

  if_fetch dut (
    .clk               (clk),
    .rst               (rst),
    .pc_i              (pc_i),
    .jump_flag_i       (jump_flag_i),
    .hold_flag_i       (hold_flag_i),
    .jtag_reset_flag_i (jtag_reset_flag_i),
    .ibus_req_o        (ibus_req_o),
    .ibus_addr_o       (ibus_addr_o),
    .ibus_gnt_i        (ibus_gnt_i),
    .ibus_rvalid_i     (ibus_rvalid_i),
    .ibus_rdata_i      (ibus_rdata_i),
    .inst_o            (inst_o),
    .inst_addr_o       (inst_addr_o),
    .inst_valid_o      (inst_valid_o),
    .stall_req_o       (stall_req_o)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_inst_o       (perf_inst_o),
    .perf_stall_o      (perf_stall_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Reference model: one open fetch (requested / granted / stale) plus a pending queue.
  bit          m_open, m_granted, m_stale;
  logic [31:0] m_faddr;
  logic [31:0] m_inst, m_iaddr;
  bit          m_valid;
  logic [63:0] m_pend[$];
  logic [31:0] m_pinst, m_pstall;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_flush();
    return jump_flag_i || jtag_reset_flag_i;
  endfunction

  function automatic bit m_held();
    return hold_flag_i >= 3'd2;
  endfunction

  function automatic bit m_deliver();
    return m_open && m_granted && ibus_rvalid_i && !m_stale && !m_flush();
  endfunction

  function automatic bit m_stall();
    return !(m_deliver() || (m_pend.size() != 0));
  endfunction

  task automatic model_reset();
    m_open = 0; m_granted = 0; m_stale = 0; m_faddr = '0;
    m_inst = NOP; m_iaddr = '0; m_valid = 0;
    m_pend.delete();
    m_pinst = '0; m_pstall = '0;
  endtask

  task automatic model_update();
    bit pend_before, loaded, stall_now, fl, hd, dv;
    if (!rst) begin
      model_reset();
      return;
    end
    pend_before = (m_pend.size() != 0);
    stall_now   = m_stall();
    fl = m_flush(); hd = m_held(); dv = m_deliver();
    loaded = 0;
    if (fl) begin
      m_inst = NOP; m_valid = 0; m_pend.delete();
    end else if (dv && hd) begin
      m_pend.push_back({m_faddr, ibus_rdata_i});
    end else if (dv) begin
      m_inst = ibus_rdata_i; m_iaddr = m_faddr; m_valid = 1; loaded = 1;
    end else if (pend_before && !hd) begin
      {m_iaddr, m_inst} = m_pend.pop_front(); m_valid = 1; loaded = 1;
    end else if (!hd) begin
      m_valid = 0;
    end
    if (!m_open) begin
      if (!fl && !hd && !pend_before) begin
        m_open = 1; m_granted = 0; m_faddr = pc_i;
      end
    end else if (!m_granted) begin
      if (fl) m_stale = 1;
      if (ibus_gnt_i) m_granted = 1;
    end else begin
      if (ibus_rvalid_i) begin
        m_open = 0; m_granted = 0; m_stale = 0;
      end else if (fl) begin
        m_stale = 1;
      end
    end
    if (loaded && m_pinst != 32'hFFFF_FFFF) m_pinst++;
    if (stall_now && m_pstall != 32'hFFFF_FFFF) m_pstall++;
    if (loaded) $display("[TB] deliver addr=%08h inst=%08h", m_iaddr, m_inst);
  endtask

  task automatic drive(input bit r, input logic [31:0] pc, input bit j, input logic [2:0] h,
                       input bit jt, input bit g, input bit rv, input logic [31:0] rd);
    rst = r; pc_i = pc; jump_flag_i = j; hold_flag_i = h; jtag_reset_flag_i = jt;
    ibus_gnt_i = g; ibus_rvalid_i = rv; ibus_rdata_i = rd;
    #1;
    chk("ibus_req", {31'd0, ibus_req_o}, {31'd0, m_open && !m_granted});
    chk("ibus_addr", ibus_addr_o, m_faddr);
    chk("stall_req", {31'd0, stall_req_o}, {31'd0, m_stall()});
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    chk("inst", inst_o, m_inst);
    chk("inst_addr", inst_addr_o, m_iaddr);
    chk("inst_valid", {31'd0, inst_valid_o}, {31'd0, m_valid});
`ifdef IF_FETCH_PERF_EN
    chk("perf_inst", perf_inst_o, m_pinst);
    chk("perf_stall", perf_stall_o, m_pstall);
`endif
  endtask

  task automatic cyc(input bit r, input logic [31:0] pc, input bit j, input logic [2:0] h,
                     input bit jt, input bit g, input bit rv, input logic [31:0] rd);
    drive(r, pc, j, h, jt, g, rv, rd);
    tick();
  endtask

  initial begin
    rst = 0; pc_i = '0; jump_flag_i = 0; hold_flag_i = '0; jtag_reset_flag_i = 0;
    ibus_gnt_i = 0; ibus_rvalid_i = 0; ibus_rdata_i = '0;
    model_reset();

    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_inst", inst_o, NOP);
    chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rst_req", {31'd0, ibus_req_o}, 32'd0);

    // 1: immediate grant and response
    cyc(1, 32'h0, 0, 0, 0, 0, 0, 0);
    chk("t1_req", {31'd0, ibus_req_o}, 32'd1);
    chk("t1_addr", ibus_addr_o, 32'h0);
    cyc(1, 32'h0, 0, 0, 0, 1, 0, 0);
    drive(1, 32'h0, 0, 0, 0, 0, 1, 32'h0010_0093);
    chk("t1_stall_rvalid", {31'd0, stall_req_o}, 32'd0);
    tick();
    chk("t1_inst", inst_o, 32'h0010_0093);
    chk("t1_iaddr", inst_addr_o, 32'h0);
    chk("t1_valid", {31'd0, inst_valid_o}, 32'd1);

    // 2: grant after three request cycles, response three cycles later
    cyc(1, 32'h4, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      drive(1, 32'h4, 0, 0, 0, (k == 2), 0, 0);
      chk("t2_addr_stable", ibus_addr_o, 32'h4);
      chk("t2_stall", {31'd0, stall_req_o}, 32'd1);
      tick();
    end
    cyc(1, 32'h4, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h4, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h4, 0, 0, 0, 0, 1, 32'h1234_5678);
    chk("t2_inst", inst_o, 32'h1234_5678);
    chk("t2_iaddr", inst_addr_o, 32'h4);

    // 3: jump while waiting drops the stale response
    cyc(1, 32'h8, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h8, 0, 0, 0, 1, 0, 0);
    cyc(1, 32'h100, 1, 0, 0, 0, 0, 0);
    chk("t3_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("t3_inst", inst_o, NOP);
    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h100, 0, 0, 0, 0, 1, 32'hBAD0_0000);
    chk("t3_drop_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("t3_drop_inst", inst_o, NOP);
    cyc(1, 32'h100, 0, 0, 0, 0, 0, 0);
    chk("t3_new_addr", ibus_addr_o, 32'h100);
    cyc(1, 32'h100, 0, 0, 0, 1, 0, 0);
    cyc(1, 32'h100, 0, 0, 0, 0, 1, 32'h0000_A0B3);

    // 4: hold parks the response in the pending buffer
    cyc(1, 32'h104, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h104, 0, 0, 0, 1, 0, 0);
    cyc(1, 32'h104, 0, 3'b010, 0, 0, 0, 0);
    cyc(1, 32'h104, 0, 3'b010, 0, 0, 1, 32'hDEAD_BEEF);
    chk("t4_frozen", inst_o, 32'h0000_A0B3);
    chk("t4_pending", {31'd0, stall_req_o}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      cyc(1, 32'h104, 0, 3'b010, 0, 0, 0, 0);
      chk("t4_no_req", {31'd0, ibus_req_o}, 32'd0);
    end
    cyc(1, 32'h104, 0, 0, 0, 0, 0, 0);
    chk("t4_inst", inst_o, 32'hDEAD_BEEF);
    chk("t4_iaddr", inst_addr_o, 32'h104);
    chk("t4_valid", {31'd0, inst_valid_o}, 32'd1);

    // 5: JTAG reset clears pending data, then discards an in-flight fetch
    cyc(1, 32'h108, 0, 0, 0, 0, 0, 0);
    cyc(1, 32'h108, 0, 0, 0, 1, 0, 0);
    cyc(1, 32'h108, 0, 3'b011, 0, 0, 1, 32'h0000_0055);
    cyc(1, 32'h200, 0, 3'b011, 1, 0, 0, 0);
    chk("t5_pend_clr", {31'd0, stall_req_o}, 32'd1);
    chk("t5_valid", {31'd0, inst_valid_o}, 32'd0);
    cyc(1, 32'h200, 0, 0, 0, 0, 0, 0);
    chk("t5_addr", ibus_addr_o, 32'h200);
    cyc(1, 32'h200, 0, 0, 1, 0, 0, 0);
    cyc(1, 32'h200, 0, 0, 0, 1, 0, 0);
    cyc(1, 32'h200, 0, 0, 0, 0, 1, 32'h0000_0077);
    chk("t5_drop_inst", inst_o, NOP);
    cyc(1, 32'h204, 0, 0, 0, 0, 0, 0);
    chk("t5_new_addr", ibus_addr_o, 32'h204);

    // 6: reset while waiting, late response ignored afterwards
    cyc(1, 32'h204, 0, 0, 0, 1, 0, 0);
    cyc(0, 32'h204, 0, 0, 0, 0, 0, 0);
    chk("t6_inst", inst_o, NOP);
    chk("t6_addr", ibus_addr_o, 32'h0);
    chk("t6_req", {31'd0, ibus_req_o}, 32'd0);
    cyc(1, 32'h204, 0, 3'b011, 0, 0, 1, 32'h0000_0099);
    chk("t6_late_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("t6_late_inst", inst_o, NOP);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      bit r, j, jt, g, rv;
      logic [2:0] h;
      r  = ($urandom_range(0, 199) != 0);
      j  = ($urandom_range(0, 99) < 6);
      jt = ($urandom_range(0, 99) < 2);
      h  = ($urandom_range(0, 9) < 7) ? 3'd0 : 3'($urandom_range(0, 7));
      g  = ($urandom_range(0, 1) == 1);
      rv = (m_open && m_granted) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 19) == 0);
      cyc(r, $urandom() & 32'hFFFF_FFFC, j, h, jt, g, rv, $urandom());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
